// File: rtl/register_pair_port.sv
// Sequences one 16-bit register-pair access into two byte accesses on the 256x8 register RAM.
// Define REGPAIR_BYTE_ACCESS_EN to add byte_en/byte_sel single-byte accesses.
module register_pair_port #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        write,
    input  logic [3:0]  level,
    input  logic [2:0]  pair,
    input  logic [15:0] wdata,
`ifdef REGPAIR_BYTE_ACCESS_EN
    input  logic        byte_en,
    input  logic        byte_sel,
`endif
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        ram_write_en,
    output logic [7:0]  ram_address,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR_F,
        WR_S,
        RD_F,
        RD_S,
        RD_TAIL
    } state_t;

    state_t      state, state_next;
    logic [7:0]  s_byte, s_byte_next;
    logic [7:0]  first_byte, first_byte_next;
    logic        single, single_next;
    logic [15:0] rdata_next;
    logic        busy_next;
    logic        done_next;
    logic        ram_write_en_next;
    logic [7:0]  ram_address_next;
    logic [7:0]  ram_wdata_next;
    logic        accept_single;
    logic        accept_sel;

`ifdef REGPAIR_BYTE_ACCESS_EN
    assign accept_single = byte_en;
    assign accept_sel    = byte_sel;
`else
    assign accept_single = 1'b0;
    assign accept_sel    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            s_byte       <= 8'h00;
            first_byte   <= 8'h00;
            single       <= 1'b0;
            rdata        <= 16'h0000;
            busy         <= 1'b0;
            done         <= 1'b0;
            ram_write_en <= 1'b0;
            ram_address  <= 8'h00;
            ram_wdata    <= 8'h00;
        end else begin
            state        <= state_next;
            s_byte       <= s_byte_next;
            first_byte   <= first_byte_next;
            single       <= single_next;
            rdata        <= rdata_next;
            busy         <= busy_next;
            done         <= done_next;
            ram_write_en <= ram_write_en_next;
            ram_address  <= ram_address_next;
            ram_wdata    <= ram_wdata_next;
        end
    end

    // The first read byte is parked in first_byte so rdata only changes on the done edge.
    always_comb begin
        state_next        = state;
        s_byte_next       = s_byte;
        first_byte_next   = first_byte;
        single_next       = single;
        rdata_next        = rdata;
        busy_next         = busy;
        done_next         = 1'b0;
        ram_write_en_next = 1'b0;
        ram_address_next  = ram_address;
        ram_wdata_next    = ram_wdata;

        case (state)
            IDLE: begin
                if (req) begin
                    busy_next        = 1'b1;
                    single_next      = accept_single;
                    s_byte_next      = BIG_ENDIAN ? wdata[7:0] : wdata[15:8];
                    ram_address_next = {level, pair, accept_single ? accept_sel : 1'b0};
                    if (write) begin
                        ram_write_en_next = 1'b1;
                        if (accept_single) begin
                            ram_wdata_next = wdata[7:0];
                            state_next     = WR_S;
                        end else begin
                            ram_wdata_next = BIG_ENDIAN ? wdata[15:8] : wdata[7:0];
                            state_next     = WR_F;
                        end
                    end else begin
                        state_next = RD_F;
                    end
                end
            end
            WR_F: begin
                ram_address_next  = {ram_address[7:1], 1'b1};
                ram_wdata_next    = s_byte;
                ram_write_en_next = 1'b1;
                state_next        = WR_S;
            end
            WR_S: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            RD_F: begin
                if (single) begin
                    state_next = RD_TAIL;
                end else begin
                    ram_address_next = {ram_address[7:1], 1'b1};
                    state_next       = RD_S;
                end
            end
            RD_S: begin
                first_byte_next = ram_rdata;
                state_next      = RD_TAIL;
            end
            RD_TAIL: begin
                if (single) begin
                    rdata_next = {8'h00, ram_rdata};
                end else if (BIG_ENDIAN) begin
                    rdata_next = {first_byte, ram_rdata};
                end else begin
                    rdata_next = {ram_rdata, first_byte};
                end
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_register_pair_port.sv
// Directed bench for register_pair_port with a 256x8 registered read-before-write RAM model.
// Byte-access scenario is included when REGPAIR_BYTE_ACCESS_EN is defined.
module tb_register_pair_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        write;
    logic [3:0]  level;
    logic [2:0]  pair;
    logic [15:0] wdata;
`ifdef REGPAIR_BYTE_ACCESS_EN
    logic        byte_en;
    logic        byte_sel;
`endif
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic        ram_write_en;
    logic [7:0]  ram_address;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [256] = '{default: 8'hFF};

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    register_pair_port #(.BIG_ENDIAN(1'b1)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .write        (write),
        .level        (level),
        .pair         (pair),
        .wdata        (wdata),
`ifdef REGPAIR_BYTE_ACCESS_EN
        .byte_en      (byte_en),
        .byte_sel     (byte_sel),
`endif
        .rdata        (rdata),
        .busy         (busy),
        .done         (done),
        .ram_write_en (ram_write_en),
        .ram_address  (ram_address),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    // Registered-output RAM; the nonblocking read returns the pre-write contents.
    always @(posedge clock) begin
        ram_rdata <= mem[ram_address];
        if (ram_write_en) mem[ram_address] <= ram_wdata;
    end

    // Presents a request and returns #1 after the accept edge.
    task automatic start_op(input bit w, input logic [3:0] lv, input logic [2:0] pr,
                            input logic [15:0] wd, input bit hold);
        req   = 1'b1;
        write = w;
        level = lv;
        pair  = pr;
        wdata = wd;
        @(posedge clock); #1;
        if (!hold) req = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen (-1 on timeout).
    task automatic wait_done(output int cycles, output int busy_hi);
        cycles  = -1;
        busy_hi = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
            if (busy === 1'b1) busy_hi++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests_run++; if (rdata !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_rdata got %0h want 0", rdata); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %0b want 0", done); end
        tests_run++; if (ram_write_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_we got %0b want 0", ram_write_en); end
        tests_run++; if (ram_address !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_addr got %0h want 0", ram_address); end
        tests_run++; if (ram_wdata !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_wdata got %0h want 0", ram_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_fresh_read();
        int cycles, busy_hi;
        start_op(1'b0, 4'd0, 3'd0, 16'h0000, 1'b0);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL fresh_accept_busy got %0b want 1", busy); end
        tests_run++; if (ram_write_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL fresh_accept_we got %0b want 0", ram_write_en); end
        wait_done(cycles, busy_hi);
        tests_run++; if (cycles !== 3) begin tests_failed++; $display("[TB] FAIL fresh_latency got %0d want 3", cycles); end
        tests_run++; if (busy_hi !== 2) begin tests_failed++; $display("[TB] FAIL fresh_busy_after_accept got %0d want 2", busy_hi); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL fresh_done_busy got %0b want 0", busy); end
        tests_run++; if (rdata !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL fresh_rdata got %0h want ffff", rdata); end
        @(posedge clock); #1;
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL fresh_done_pulse got %0b want 0", done); end
        tests_run++; if (rdata !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL fresh_rdata_hold got %0h want ffff", rdata); end
    endtask

    task automatic test_write_read();
        int cycles, busy_hi;
        start_op(1'b1, 4'd3, 3'd5, 16'hA55A, 1'b0);
        tests_run++; if (ram_write_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_accept_we got %0b want 1", ram_write_en); end
        tests_run++; if (ram_address !== 8'h3A) begin tests_failed++; $display("[TB] FAIL wr_accept_addr got %0h want 3a", ram_address); end
        tests_run++; if (ram_wdata !== 8'hA5) begin tests_failed++; $display("[TB] FAIL wr_accept_wdata got %0h want a5", ram_wdata); end
        wait_done(cycles, busy_hi);
        tests_run++; if (cycles !== 2) begin tests_failed++; $display("[TB] FAIL wr_latency got %0d want 2", cycles); end
        tests_run++; if (ram_write_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_done_we got %0b want 0", ram_write_en); end
        tests_run++; if (mem[8'h3A] !== 8'hA5) begin tests_failed++; $display("[TB] FAIL wr_mem3a got %0h want a5", mem[8'h3A]); end
        tests_run++; if (mem[8'h3B] !== 8'h5A) begin tests_failed++; $display("[TB] FAIL wr_mem3b got %0h want 5a", mem[8'h3B]); end
        start_op(1'b0, 4'd3, 3'd5, 16'h0000, 1'b0);
        wait_done(cycles, busy_hi);
        tests_run++; if (cycles !== 3) begin tests_failed++; $display("[TB] FAIL rd_latency got %0d want 3", cycles); end
        tests_run++; if (rdata !== 16'hA55A) begin tests_failed++; $display("[TB] FAIL rd_rdata got %0h want a55a", rdata); end
    endtask

    task automatic test_back_to_back();
        int cycles, busy_hi;
        start_op(1'b1, 4'd15, 3'd7, 16'h1234, 1'b1);
        tests_run++; if (ram_address !== 8'hFE) begin tests_failed++; $display("[TB] FAIL b2b_wr_addr got %0h want fe", ram_address); end
        wait_done(cycles, busy_hi);
        tests_run++; if (cycles !== 2) begin tests_failed++; $display("[TB] FAIL b2b_wr_latency got %0d want 2", cycles); end
        write = 1'b0;
        @(posedge clock); #1;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_rd_accept_busy got %0b want 1", busy); end
        tests_run++; if (ram_address !== 8'hFE) begin tests_failed++; $display("[TB] FAIL b2b_rd_addr got %0h want fe", ram_address); end
        tests_run++; if (ram_write_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_rd_we got %0b want 0", ram_write_en); end
        req = 1'b0;
        wait_done(cycles, busy_hi);
        tests_run++; if (cycles !== 3) begin tests_failed++; $display("[TB] FAIL b2b_rd_latency got %0d want 3", cycles); end
        tests_run++; if (rdata !== 16'h1234) begin tests_failed++; $display("[TB] FAIL b2b_rdata got %0h want 1234", rdata); end
        tests_run++; if (mem[8'hFE] !== 8'h12) begin tests_failed++; $display("[TB] FAIL b2b_memfe got %0h want 12", mem[8'hFE]); end
        tests_run++; if (mem[8'hFF] !== 8'h34) begin tests_failed++; $display("[TB] FAIL b2b_memff got %0h want 34", mem[8'hFF]); end
    endtask

    // Reset is taken on the edge that would otherwise move the write into WR_S.
    task automatic test_reset_mid_write();
        int cycles, busy_hi;
        start_op(1'b1, 4'd1, 3'd2, 16'hBEEF, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy got %0b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_done got %0b want 0", done); end
        tests_run++; if (ram_write_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_we got %0b want 0", ram_write_en); end
        tests_run++; if (ram_address !== 8'h00) begin tests_failed++; $display("[TB] FAIL abort_addr got %0h want 0", ram_address); end
        tests_run++; if (ram_wdata !== 8'h00) begin tests_failed++; $display("[TB] FAIL abort_wdata got %0h want 0", ram_wdata); end
        tests_run++; if (rdata !== 16'h0000) begin tests_failed++; $display("[TB] FAIL abort_rdata got %0h want 0", rdata); end
        @(posedge clock); #1;
        tests_run++; if (mem[8'h14] !== 8'hBE) begin tests_failed++; $display("[TB] FAIL abort_mem14 got %0h want be", mem[8'h14]); end
        tests_run++; if (mem[8'h15] !== 8'hFF) begin tests_failed++; $display("[TB] FAIL abort_mem15 got %0h want ff", mem[8'h15]); end
        start_op(1'b0, 4'd1, 3'd2, 16'h0000, 1'b0);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_next_busy got %0b want 1", busy); end
        wait_done(cycles, busy_hi);
        tests_run++; if (cycles !== 3) begin tests_failed++; $display("[TB] FAIL abort_next_latency got %0d want 3", cycles); end
        tests_run++; if (rdata !== 16'hBEFF) begin tests_failed++; $display("[TB] FAIL abort_next_rdata got %0h want beff", rdata); end
    endtask

    task automatic test_ignore_while_busy();
        int done_count, done_at, extra_busy;
        done_count = 0;
        done_at    = -1;
        extra_busy = 0;
        start_op(1'b1, 4'd4, 3'd1, 16'h5678, 1'b0);
        tests_run++; if (ram_wdata !== 8'h56) begin tests_failed++; $display("[TB] FAIL busy_accept_wdata got %0h want 56", ram_wdata); end
        req   = 1'b1;
        write = 1'b0;
        wdata = 16'hFFFF;
        level = 4'd9;
        pair  = 3'd3;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1) begin
                done_count++;
                if (done_at < 0) done_at = i;
            end
            if (i >= 3 && busy === 1'b1) extra_busy++;
            if (i == 1) begin
                tests_run++; if (ram_address !== 8'h43) begin tests_failed++; $display("[TB] FAIL busy_s_addr got %0h want 43", ram_address); end
                tests_run++; if (ram_wdata !== 8'h78) begin tests_failed++; $display("[TB] FAIL busy_s_wdata got %0h want 78", ram_wdata); end
                write = 1'b1;
                wdata = 16'h0000;
            end
            if (i == 2) req = 1'b0;
        end
        tests_run++; if (done_count !== 1) begin tests_failed++; $display("[TB] FAIL busy_done_count got %0d want 1", done_count); end
        tests_run++; if (done_at !== 2) begin tests_failed++; $display("[TB] FAIL busy_done_at got %0d want 2", done_at); end
        tests_run++; if (extra_busy !== 0) begin tests_failed++; $display("[TB] FAIL busy_extra_accept got %0d want 0", extra_busy); end
        tests_run++; if (mem[8'h42] !== 8'h56) begin tests_failed++; $display("[TB] FAIL busy_mem42 got %0h want 56", mem[8'h42]); end
        tests_run++; if (mem[8'h43] !== 8'h78) begin tests_failed++; $display("[TB] FAIL busy_mem43 got %0h want 78", mem[8'h43]); end
    endtask

`ifdef REGPAIR_BYTE_ACCESS_EN
    task automatic test_byte_access();
        int cycles, busy_hi;
        byte_en  = 1'b1;
        byte_sel = 1'b1;
        start_op(1'b1, 4'd2, 3'd0, 16'h00C3, 1'b0);
        tests_run++; if (ram_write_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL byte_wr_we got %0b want 1", ram_write_en); end
        tests_run++; if (ram_address !== 8'h21) begin tests_failed++; $display("[TB] FAIL byte_wr_addr got %0h want 21", ram_address); end
        tests_run++; if (ram_wdata !== 8'hC3) begin tests_failed++; $display("[TB] FAIL byte_wr_wdata got %0h want c3", ram_wdata); end
        wait_done(cycles, busy_hi);
        tests_run++; if (cycles !== 1) begin tests_failed++; $display("[TB] FAIL byte_wr_latency got %0d want 1", cycles); end
        tests_run++; if (ram_write_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL byte_wr_done_we got %0b want 0", ram_write_en); end
        tests_run++; if (mem[8'h21] !== 8'hC3) begin tests_failed++; $display("[TB] FAIL byte_mem21 got %0h want c3", mem[8'h21]); end
        tests_run++; if (mem[8'h20] !== 8'hFF) begin tests_failed++; $display("[TB] FAIL byte_mem20 got %0h want ff", mem[8'h20]); end
        start_op(1'b0, 4'd2, 3'd0, 16'h0000, 1'b0);
        wait_done(cycles, busy_hi);
        tests_run++; if (cycles !== 2) begin tests_failed++; $display("[TB] FAIL byte_rd_latency got %0d want 2", cycles); end
        tests_run++; if (rdata !== 16'h00C3) begin tests_failed++; $display("[TB] FAIL byte_rd_rdata got %0h want 00c3", rdata); end
        byte_en  = 1'b0;
        byte_sel = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        write = 1'b0;
        level = 4'd0;
        pair  = 3'd0;
        wdata = 16'h0000;
`ifdef REGPAIR_BYTE_ACCESS_EN
        byte_en  = 1'b0;
        byte_sel = 1'b0;
`endif
        test_reset();
        test_fresh_read();
        test_write_read();
        test_back_to_back();
        test_reset_mid_write();
        test_ignore_while_busy();
`ifdef REGPAIR_BYTE_ACCESS_EN
        test_byte_access();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
